// File: rtl/pulse_capture_pkg.sv
// pulse_capture_pkg: shared widths, channel count and channel state type
// for the two-channel pulse-width capture block.
package pulse_capture_pkg;

  localparam int WIDTH_BITS  = 12;
  localparam int PERIOD_BITS = 16;
  localparam int NUM_CH      = 2;

  // ARM waits for a low level so a pulse already high at reset release is
  // never measured; IDLE waits for a rising edge; MEAS counts high time.
  typedef enum logic [1:0] {
    ARM  = 2'd0,
    IDLE = 2'd1,
    MEAS = 2'd2
  } chanState_e;

endpackage

// File: rtl/pulse_meter.sv
// pulse_meter: one capture channel. Synchronises the pin, runs the
// ARM/IDLE/MEAS state machine, measures high time in prescaled ticks and
// flags a channel whose pulses have stopped arriving.
module pulse_meter
  import pulse_capture_pkg::*;
#(
  parameter int PRESCALE      = 50,
  parameter int TIMEOUT_TICKS = 200
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_pulse,
  output logic [WIDTH_BITS-1:0] o_width,
  output logic                  o_capValid,
  output logic                  o_stale
);

  localparam int                     PRE_BITS   = $clog2(PRESCALE);
  localparam logic [PRE_BITS-1:0]    PRE_LAST   = PRE_BITS'(PRESCALE - 1);
  localparam logic [PERIOD_BITS-1:0] STALE_LAST = PERIOD_BITS'(TIMEOUT_TICKS - 1);

  logic                   r_meta;
  logic                   r_sync;
  logic                   r_syncD;
  logic [1:0]             r_fill;
  chanState_e             r_state;
  logic [PRE_BITS-1:0]    r_presc;
  logic [WIDTH_BITS-1:0]  r_width;
  logic [WIDTH_BITS-1:0]  r_widthOut;
  logic [PERIOD_BITS-1:0] r_period;
  logic                   r_capValid;
  logic                   r_stale;

  logic                   w_rise;
  logic                   w_fall;
  logic                   w_tick;
  logic                   w_start;
  logic [WIDTH_BITS-1:0]  w_widthNext;
  logic [PERIOD_BITS-1:0] w_periodNext;

  assign w_rise       = r_sync & ~r_syncD;
  assign w_fall       = ~r_sync & r_syncD;
  assign w_tick       = (r_presc == PRE_LAST);
  assign w_start      = (r_state == IDLE) && w_rise;
  assign w_widthNext  = (w_tick && (r_width != '1)) ? r_width + WIDTH_BITS'(1) : r_width;
  assign w_periodNext = (w_tick && (r_period != '1)) ? r_period + PERIOD_BITS'(1) : r_period;

  // Two-flop synchronizer, a delayed copy for edge detection, and a fill
  // marker that tells ARM when the synchronized level reflects the real pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_syncD <= 1'b0;
      r_fill  <= 2'b00;
    end else begin
      r_meta  <= i_pulse;
      r_sync  <= r_meta;
      r_syncD <= r_sync;
      r_fill  <= {r_fill[0], 1'b1};
    end
  end

  // Channel state machine; the fall latches the width including a tick
  // landing on that same cycle, so the result is floor(high/PRESCALE).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ARM;
      r_width    <= '0;
      r_widthOut <= '0;
      r_capValid <= 1'b0;
    end else begin
      r_capValid <= 1'b0;
      case (r_state)
        ARM: begin
          if (r_fill[1] && !r_sync) r_state <= IDLE;
        end
        IDLE: begin
          if (w_rise) begin
            r_state <= MEAS;
            r_width <= '0;
          end
        end
        MEAS: begin
          if (w_fall) begin
            r_state    <= IDLE;
            r_widthOut <= w_widthNext;
            r_capValid <= 1'b1;
          end else begin
            r_width <= w_widthNext;
          end
        end
        default: r_state <= ARM;
      endcase
    end
  end

  // Free-running prescaler realigned on each rising edge, saturating period
  // counter, and the stale flag that a completed capture clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc  <= '0;
      r_period <= '0;
      r_stale  <= 1'b0;
    end else begin
      if (w_start || w_tick) r_presc <= '0;
      else                   r_presc <= r_presc + PRE_BITS'(1);
      if (w_start) r_period <= '0;
      else         r_period <= w_periodNext;
      if (r_capValid) r_stale <= 1'b0;
      else if (!w_start && w_tick && (r_period == STALE_LAST)) r_stale <= 1'b1;
    end
  end

  assign o_width    = r_widthOut;
  assign o_capValid = r_capValid;
  assign o_stale    = r_stale;

endmodule

// File: rtl/pulse_capture.sv
// pulse_capture: two independent pulse-width channels plus the shared
// sticky new-data flags, read strobe handling and output packing.
module pulse_capture
  import pulse_capture_pkg::*;
#(
  parameter int PRESCALE      = 50,
  parameter int TIMEOUT_TICKS = 200
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            pulse_in,
  output logic [NUM_CH*WIDTH_BITS-1:0] out_data,
  output logic [NUM_CH-1:0]            out_new,
  output logic [NUM_CH-1:0]            out_stale,
  input  logic                         out_rd
);

  logic [NUM_CH-1:0][WIDTH_BITS-1:0] w_width;
  logic [NUM_CH-1:0]                 w_capValid;
  logic [NUM_CH-1:0]                 w_stale;
  logic [NUM_CH-1:0][WIDTH_BITS-1:0] r_data;
  logic [NUM_CH-1:0]                 r_new;

  for (genvar gCh = 0; gCh < NUM_CH; gCh++) begin : gChan
    pulse_meter #(
      .PRESCALE      (PRESCALE),
      .TIMEOUT_TICKS (TIMEOUT_TICKS)
    ) u_meter (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_pulse    (pulse_in[gCh]),
      .o_width    (w_width[gCh]),
      .o_capValid (w_capValid[gCh]),
      .o_stale    (w_stale[gCh])
    );
  end

  // Publish each capture and raise its sticky flag; a capture in the same
  // cycle as the read strobe keeps its flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_new  <= '0;
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (w_capValid[ch]) r_data[ch] <= w_width[ch];
      end
      r_new <= w_capValid | (r_new & {NUM_CH{~out_rd}});
    end
  end

  assign out_data  = r_data;
  assign out_new   = r_new;
  assign out_stale = w_stale;

endmodule

// File: tb/tb_pulse_capture.sv
// tb_pulse_capture: directed bench for pulse_capture with hand-computed
// widths (PRESCALE=50, TIMEOUT_TICKS=200) plus a fast-tick instance.
module tb_pulse_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  pulseIn;
  logic        outRd;
  logic [23:0] outData;
  logic [1:0]  outNew;
  logic [1:0]  outStale;

  logic [1:0]  satPulse;
  logic        satRd;
  logic [23:0] satData;
  logic [1:0]  satNew;
  logic [1:0]  satStale;

  int nChecks  = 0;
  int nBad     = 0;
  int cyc      = 0;
  int lastRise = 0;

  // Free-running 100 MHz-style clock and an edge counter used to time
  // checks relative to the last driven rising edge.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  pulse_capture #(
    .PRESCALE      (50),
    .TIMEOUT_TICKS (200)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pulse_in  (pulseIn),
    .out_data  (outData),
    .out_new   (outNew),
    .out_stale (outStale),
    .out_rd    (outRd)
  );

  // Second instance with a 2-cycle tick so the 12-bit width saturates
  // within a short pulse.
  pulse_capture #(
    .PRESCALE      (2),
    .TIMEOUT_TICKS (200)
  ) u_dutSat (
    .clk       (clk),
    .rst_n     (rst_n),
    .pulse_in  (satPulse),
    .out_data  (satData),
    .out_new   (satNew),
    .out_stale (satStale),
    .out_rd    (satRd)
  );

  // Count one comparison and report it when observed and expected differ.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nBad++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", tag, actual, expected);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raise the masked channels for highCycles clock edges, then drop them.
  task automatic applyStimulus(input logic [1:0] mask, input int highCycles);
    pulseIn  = pulseIn | mask;
    lastRise = cyc;
    waitCycles(highCycles);
    pulseIn  = pulseIn & ~mask;
  endtask

  // Directed sequence: reset, boot timeout, latency, widths, arming, read
  // strobe collision, stale timing, async reset and saturation.
  initial begin
    rst_n    = 1'b0;
    pulseIn  = 2'b00;
    outRd    = 1'b0;
    satPulse = 2'b00;
    satRd    = 1'b0;
    waitCycles(3);
    checkOutput("rst_data", 32'(outData), 0);
    checkOutput("rst_new", 32'(outNew), 0);
    checkOutput("rst_stale", 32'(outStale), 0);
    rst_n = 1'b1;

    waitCycles(9999);
    checkOutput("boot_stale_pre", 32'(outStale), 0);
    waitCycles(1);
    checkOutput("boot_stale_set", 32'(outStale), 3);
    checkOutput("boot_stale_sat", 32'(satStale), 3);

    applyStimulus(2'b01, 1500);
    waitCycles(3);
    checkOutput("ch0_new_lat3", 32'(outNew), 0);
    checkOutput("ch0_data_lat3", 32'(outData[11:0]), 0);
    waitCycles(1);
    checkOutput("ch0_new_lat4", 32'(outNew), 1);
    checkOutput("ch0_w1500", 32'(outData[11:0]), 30);
    checkOutput("ch0_stale_clr", 32'(outStale), 2);
    waitCycles(3496);
    outRd = 1'b1;
    waitCycles(1);
    outRd = 1'b0;
    checkOutput("rd_clear", 32'(outNew), 0);

    applyStimulus(2'b10, 1549);
    waitCycles(4);
    checkOutput("ch1_w1549", 32'(outData[23:12]), 30);
    checkOutput("ch1_new", 32'(outNew), 2);
    checkOutput("ch0_hold", 32'(outData[11:0]), 30);
    waitCycles(100);
    applyStimulus(2'b10, 1550);
    waitCycles(4);
    checkOutput("ch1_w1550", 32'(outData[23:12]), 31);
    waitCycles(100);

    rst_n   = 1'b0;
    pulseIn = 2'b11;
    waitCycles(3);
    rst_n = 1'b1;
    waitCycles(500);
    pulseIn = 2'b00;
    waitCycles(20);
    checkOutput("arm_new", 32'(outNew), 0);
    checkOutput("arm_data", 32'(outData), 0);
    applyStimulus(2'b11, 1000);
    waitCycles(4);
    checkOutput("both_data", 32'(outData), (20 << 12) | 20);
    checkOutput("both_new", 32'(outNew), 3);

    waitCycles(100);
    outRd = 1'b1;
    waitCycles(1);
    outRd = 1'b0;
    checkOutput("rd_clear2", 32'(outNew), 0);
    waitCycles(50);
    applyStimulus(2'b01, 1500);
    waitCycles(3);
    outRd = 1'b1;
    waitCycles(1);
    outRd = 1'b0;
    checkOutput("rd_collide_new", 32'(outNew), 1);
    checkOutput("rd_collide_w", 32'(outData[11:0]), 30);
    outRd = 1'b1;
    waitCycles(1);
    outRd = 1'b0;
    checkOutput("rd_lone", 32'(outNew), 0);

    // The rising edge acts 3 edges after the pin (2 sync flops + edge
    // register), so the 200-tick timeout lands 10003 edges after the pin.
    waitCycles(lastRise + 10002 - cyc);
    checkOutput("stale0_pre", 32'(outStale[0]), 0);
    waitCycles(1);
    checkOutput("stale0_set", 32'(outStale[0]), 1);
    checkOutput("stale0_data", 32'(outData[11:0]), 30);
    applyStimulus(2'b01, 1000);
    waitCycles(3);
    checkOutput("stale0_lat3", 32'(outStale[0]), 1);
    waitCycles(1);
    checkOutput("stale0_clr", 32'(outStale[0]), 0);
    checkOutput("stale0_w", 32'(outData[11:0]), 20);

    waitCycles(50);
    pulseIn = 2'b01;
    waitCycles(800);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_data", 32'(outData), 0);
    checkOutput("arst_new", 32'(outNew), 0);
    checkOutput("arst_stale", 32'(outStale), 0);
    waitCycles(2);
    rst_n = 1'b1;
    waitCycles(300);
    pulseIn = 2'b00;
    waitCycles(20);
    checkOutput("arst_discard_new", 32'(outNew), 0);
    checkOutput("arst_discard_data", 32'(outData), 0);

    applyStimulus(2'b01, 49);
    waitCycles(4);
    checkOutput("zero_new", 32'(outNew), 1);
    checkOutput("zero_w", 32'(outData[11:0]), 0);
    applyStimulus(2'b10, 50);
    waitCycles(4);
    checkOutput("one_w", 32'(outData[23:12]), 1);
    checkOutput("one_new", 32'(outNew), 3);

    satPulse = 2'b10;
    waitCycles(8189);
    satPulse = 2'b00;
    waitCycles(4);
    checkOutput("sat_w8189", 32'(satData[23:12]), 4094);
    waitCycles(20);
    satPulse = 2'b10;
    waitCycles(9000);
    satPulse = 2'b00;
    waitCycles(4);
    checkOutput("sat_w9000", 32'(satData[23:12]), 4095);
    checkOutput("sat_ch0", 32'(satData[11:0]), 0);

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule

// File: doc/pulse_capture.md
PULSE_CAPTURE -- requirements
Module: pulse_capture

Interface
REQ-001 Parameter PRESCALE, default 50: clk cycles per measurement tick; SHALL be ≥ 2.
REQ-002 Parameter TIMEOUT_TICKS, default 200: ticks after a rising edge with no new rising edge before a channel is declared stale; SHALL be 1..65535.
REQ-003 Port clk, input, 1: single clock; all state on rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 Port pulse_in, input, 2: asynchronous servo/RC pulse inputs; bit 0 = channel 0, bit 1 = channel 1.
REQ-006 Port out_data, output, 24: {width1[11:0], width0[11:0]}, the latest completed pulse widths in ticks.
REQ-007 Port out_new, output, 2: sticky per-channel flag; bit set means a new width was captured since the last out_rd.
REQ-008 Port out_stale, output, 2: per-channel timeout flag.
REQ-009 Port out_rd, input, 1: single-cycle read strobe that clears out_new.

Function
REQ-010 Each pulse_in bit SHALL pass through a 2-FF synchronizer reset to 0; edges are detected on the synchronized level against a 1-cycle delayed copy.
REQ-011 Each channel SHALL have a state machine: ARM -> IDLE when the synchronized level is 0; IDLE -> MEAS on a rising edge; MEAS -> IDLE on a falling edge.
REQ-012 ARM SHALL ignore a pulse already high at reset release, so no partial pulse is measured.
REQ-013 On a rising edge, the channel's prescaler (0..PRESCALE-1) and width counter SHALL clear to 0; the prescaler then runs freely; a tick is the cycle the prescaler equals PRESCALE-1.
REQ-014 In MEAS, each tick SHALL increment the 12-bit width counter, saturating at 4095 with no wrap.
REQ-015 Width result for a synchronized high time of H cycles SHALL be min(floor(H/PRESCALE), 4095).
REQ-016 On a falling edge in MEAS, the width counter SHALL be latched into the channel's out_data field, and out_new[ch] SHALL be set in the following cycle.
REQ-017 Total latency from the pin falling to out_data/out_new update SHALL be 4 clk cycles.
REQ-018 A 16-bit period counter SHALL count ticks since the last rising edge, saturating.
REQ-019 out_stale[ch] SHALL set when the period counter reaches TIMEOUT_TICKS, or when TIMEOUT_TICKS ticks elapse in ARM/IDLE after reset with no rising edge.
REQ-020 out_stale[ch] SHALL clear on the next completed capture (REQ-016); out_data is retained while stale.
REQ-021 out_rd SHALL clear both out_new bits the cycle after the strobe.
REQ-022 If out_rd and a capture occur in the same cycle, the capture SHALL win and out_new[ch] stays 1.
REQ-023 Channels SHALL be fully independent; simultaneous captures on both channels SHALL both be reflected.
REQ-024 A zero-width result (H < PRESCALE) SHALL still be captured as 0 and set out_new.

Reset
REQ-025 While rst_n=0, state SHALL be ARM for both channels, and the synchronizers, counters, out_data, out_new and out_stale SHALL all be 0.
REQ-026 Asserting reset mid-measurement SHALL discard the pulse; after release, the channel re-arms per REQ-012.

Structure
REQ-027 A shared package SHALL hold the WIDTH_BITS=12 and PERIOD_BITS=16 constants and the channel state enum {ARM, IDLE, MEAS}.
REQ-028 A per-channel sub-module pulse_meter (synchronizer, FSM, prescaler, counters, stale logic) SHALL be instantiated twice; the top level holds out_new/out_rd logic and packing.

Verification (PRESCALE=50, TIMEOUT_TICKS=200)
REQ-029 Ch0 high 1500 cycles, low 3500 -> width0=30, out_new=01, 4 cycles after the fall.
REQ-030 Ch1 high 1549 cycles -> width1=30; then high 1550 -> width1=31; then high held 300000 cycles -> width1=4095 (saturated).
REQ-031 pulse_in=11 at reset release, falls after 500 cycles -> no capture, out_new=00; the next 1000-cycle pulse -> width=20.
REQ-032 out_rd strobed in the same cycle ch0 sets out_new -> out_new[0] remains 1; a further lone out_rd -> out_new=00.
REQ-033 Ch0 pulses stop after one capture -> out_stale[0]=1 exactly 10000 cycles after the last rising edge, out_data unchanged; the next pulse clears it.
REQ-034 rst_n driven low mid-pulse (ch0 high 800 cycles) -> all outputs 0 asynchronously; the remainder of that pulse is ignored.
